// File: rtl/iob_sync_fifo_asym_r_big.sv
// Single-clock FIFO: narrow write port, wide read port; RATIO narrow writes pack into one read word.
// Optional sticky drop flags w_err/r_err are present when IOB_FIFO_ERR_EN is defined.
module iob_sync_fifo_asym_r_big #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                empty,
  output logic [ADDR_W:0]     level
`ifdef IOB_FIFO_ERR_EN
  ,
  output logic                w_err,
  output logic                r_err
`endif
);

  localparam int RATIO    = R_DATA_W / W_DATA_W;
  localparam int RATIO_W  = $clog2(RATIO);
  localparam int R_ADDR_W = ADDR_W - RATIO_W;
  localparam int DEPTH    = 2 ** ADDR_W;

  // Request semantics: w_en/r_en are requests, !full/!empty act as ready;
  // a transfer happens only in a cycle where both are high at the clock edge,
  // and requests against a low ready are dropped without side effects.

  logic [W_DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]     w_ptr, w_ptr_nxt;
  logic [R_ADDR_W:0]   r_ptr, r_ptr_nxt;
  logic [ADDR_W:0]     level_nxt;
  logic                w_acc, r_acc;
  logic [R_DATA_W-1:0] rd_word;

  always_comb begin
    w_acc     = w_en && !full;
    r_acc     = r_en && !empty;
    w_ptr_nxt = w_acc ? w_ptr + (ADDR_W+1)'(1) : w_ptr;
    r_ptr_nxt = r_acc ? r_ptr + (R_ADDR_W+1)'(1) : r_ptr;
    // Occupancy is the pointer distance with r_ptr scaled up to narrow units.
    level_nxt = w_ptr_nxt - {r_ptr_nxt, {RATIO_W{1'b0}}};
  end

  // Earliest-written narrow word of the group lands in the LSBs.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      rd_word[i*W_DATA_W +: W_DATA_W] = mem[{r_ptr[R_ADDR_W-1:0], RATIO_W'(i)}];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) mem[w_ptr[ADDR_W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      w_ptr   <= w_ptr_nxt;
      r_ptr   <= r_ptr_nxt;
      level   <= level_nxt;
      full    <= (level_nxt == (ADDR_W+1)'(DEPTH));
      empty   <= (level_nxt < (ADDR_W+1)'(RATIO));
      r_valid <= r_acc;
      if (r_acc) r_data <= rd_word;
    end
  end

`ifdef IOB_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_err <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_en && full)  w_err <= 1'b1;
      if (r_en && empty) r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/iob_sync_fifo_asym_r_big.md
Name: iob_sync_fifo_asym_r_big

Overview:
Single-clock FIFO with a narrow write port and a wide read port. It packs RATIO consecutive narrow writes into one wide read word. It sits directly upstream of a wide consumer and owns the write/read pointer logic, flags and storage that feed a narrow-write/wide-read dual-port memory. Storage is an internal array of 2**ADDR_W narrow words. The read side addresses it as {r_ptr, lsb} groups.

Parameters:
W_DATA_W, 8, write (narrow) data width
R_DATA_W, 32, read (wide) data width; must equal W_DATA_W * RATIO, with RATIO a power of 2 and RATIO >= 2
ADDR_W, 6, log2 of depth in narrow words; must be > log2(RATIO)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
w_en  input  1  write request
w_data  input  W_DATA_W  narrow write data
full  output  1  no narrow slot free
r_en  input  1  read request
r_data  output  R_DATA_W  wide read data, registered
r_valid  output  1  pulses when r_data has been updated by an accepted read
empty  output  1  fewer than RATIO narrow words stored
level  output  ADDR_W+1  occupancy in narrow words

Behaviour:
- Derived constants: RATIO = R_DATA_W/W_DATA_W; R_ADDR_W = ADDR_W - log2(RATIO).
- Pointers:
  - w_ptr is ADDR_W+1 bits, in narrow units.
  - r_ptr is R_ADDR_W+1 bits, in wide units.
  - Both wrap naturally modulo their width.
- Occupancy and flags:
  - level = w_ptr - {r_ptr, log2(RATIO) zeros}, held in a register.
  - full = (level == 2**ADDR_W).
  - empty = (level < RATIO).
  - All three are registered and consistent with each other every cycle.
- Write acceptance: a write is accepted when w_en && !full. It stores w_data at mem[w_ptr[ADDR_W-1:0]] and increments w_ptr. A write while full is dropped; no state changes.
- Read acceptance: a read is accepted when r_en && !empty. It increments r_ptr.
- Read data:
  - On the next rising edge, r_data[(i+1)*W_DATA_W-1 -: W_DATA_W] = mem[{r_ptr_old[R_ADDR_W-1:0], i}] for i = 0..RATIO-1.
  - The earliest-written narrow word lands in the LSBs.
  - Read latency is 1 cycle; r_valid is high for exactly that cycle.
  - A read while empty is dropped: r_data holds and r_valid = 0.
- Simultaneous events:
  - Acceptance of each side is decided from the flags at the start of the cycle.
  - Both accepted in the same cycle: level_next = level + 1 - RATIO.
  - A write is not accepted when full, even with a concurrent accepted read. No write-through.
  - A read never returns data written in the same cycle.
- r_data holds its value between reads.
- Reset values (asynchronous, take effect immediately without a clock edge):
  - w_ptr = 0, r_ptr = 0, level = 0
  - full = 0, empty = 1
  - r_data = 0, r_valid = 0
- Memory contents are not reset.
- Reset mid-operation discards all stored data and drops any in-flight read result (r_valid = 0).
- Wrap-around: after 2**ADDR_W narrow writes, w_ptr's MSB toggles. Full/empty stay correct across any number of wraps.

Optional Feature:
IOB_FIFO_ERR_EN:
- When defined, adds output ports w_err (1) and r_err (1).
- w_err is a sticky flag set on the edge after any dropped write (w_en && full).
- r_err is a sticky flag set on the edge after any dropped read (r_en && empty).
- Both are cleared only by rst, reset value 0.
- When not defined, the ports do not exist and dropped requests are silently ignored. Behaviour is otherwise identical.

Test Plan:
All tests use W_DATA_W=8, R_DATA_W=32, ADDR_W=4 (16 narrow / 4 wide entries).
1. Assert rst with no clock -> immediately empty=1, full=0, level=0, r_data=0, r_valid=0.
2. Write 0x11,0x22,0x33 -> level=3, empty=1. r_en now is dropped: r_valid=0, r_err=1 if enabled. Write 0x44 -> empty=0, level=4. r_en -> next cycle r_data=0x44332211, r_valid=1, level=0, empty=1.
3. Write 0x00..0x0F -> full=1, level=16. Write 0xFF -> dropped, level stays 16, w_err=1 if enabled. Four reads -> 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. Then empty=1.
4. With level=4, assert w_en (0xAA) and r_en in the same cycle -> level=1, empty=1, full=0, r_data = previously stored word.
5. With full=1, assert w_en and r_en together -> read accepted, write dropped, level=12.
6. Stream 64 writes with a read every 4th cycle (pointer wrap) -> all 16 wide words returned in order. Assert rst mid-stream at level=8 -> immediately level=0, empty=1, r_valid=0.
